// File: rtl/rv32i_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_wb_arbiter_if
// Purpose  : Bundles the execution-unit result handshakes and the register
//            file write port / result bus of the write-back arbiter.
// Signals  : i_flush     - pipeline flush, drops all buffered results
//            i_req_vld   - per-unit result valid
//            o_req_rdy   - per-unit ready (transfer on vld & rdy)
//            i_req_idx   - packed destination tags, unit i at [i*PHYS_IDX_BW +: PHYS_IDX_BW]
//            i_req_data  - packed result data, same packing
//            o_wen       - RF write enable / result-bus valid
//            o_wr_idx    - RF write tag
//            o_wdata     - RF write data
//            o_grant     - one-hot source of the current write
//            o_busy      - any result still buffered
// Modports : master - execution-unit side, slave - arbiter side
// Revision : 1.0 - initial release
// ============================================================================
interface rv32i_wb_arbiter_if #(
    parameter int NUM_REQ     = 3,
    parameter int PHYS_IDX_BW = 6,
    parameter int DATA_BW     = 32
);
    logic                           i_flush;
    logic [NUM_REQ-1:0]             i_req_vld;
    logic [NUM_REQ-1:0]             o_req_rdy;
    logic [NUM_REQ*PHYS_IDX_BW-1:0] i_req_idx;
    logic [NUM_REQ*DATA_BW-1:0]     i_req_data;
    logic                           o_wen;
    logic [PHYS_IDX_BW-1:0]         o_wr_idx;
    logic [DATA_BW-1:0]             o_wdata;
    logic [NUM_REQ-1:0]             o_grant;
    logic                           o_busy;

    modport master (
        output i_flush, i_req_vld, i_req_idx, i_req_data,
        input  o_req_rdy, o_wen, o_wr_idx, o_wdata, o_grant, o_busy
    );

    modport slave (
        input  i_flush, i_req_vld, i_req_idx, i_req_data,
        output o_req_rdy, o_wen, o_wr_idx, o_wdata, o_grant, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/rv32i_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_wb_arbiter
// Purpose  : Write-back arbiter for the single physical register file write
//            port. Each execution unit feeds a small skid FIFO; one head is
//            granted per cycle in round-robin order and written out through
//            a registered RF port that doubles as the result bus.
// Ports    : clk  - clock
//            rstn - synchronous active-low reset
//            bus  - rv32i_wb_arbiter_if.slave (handshakes + RF write port)
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_wb_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int PHYS_IDX_BW = 6,
    parameter int DATA_BW     = 32,
    parameter int BUF_DEPTH   = 2
) (
    input  wire logic           clk,
    input  wire logic           rstn,
    rv32i_wb_arbiter_if.slave   bus
);

    localparam int PTR_BW = $clog2(BUF_DEPTH);
    localparam int CNT_BW = $clog2(BUF_DEPTH + 1);
    localparam int RR_BW  = $clog2(NUM_REQ);

    localparam logic [CNT_BW-1:0] CNT_FULL = CNT_BW'(BUF_DEPTH);
    localparam logic [CNT_BW-1:0] CNT_ONE  = CNT_BW'(1);
    localparam logic [PTR_BW-1:0] PTR_ONE  = PTR_BW'(1);
    localparam logic [RR_BW-1:0]  RR_LAST  = RR_BW'(NUM_REQ - 1);

    // FIFO storage; pointers wrap for free because BUF_DEPTH is a power of 2
    logic [PHYS_IDX_BW-1:0] idx_mem  [NUM_REQ][BUF_DEPTH];
    logic [DATA_BW-1:0]     data_mem [NUM_REQ][BUF_DEPTH];
    logic [PTR_BW-1:0]      wr_ptr   [NUM_REQ];
    logic [PTR_BW-1:0]      rd_ptr   [NUM_REQ];
    logic [CNT_BW-1:0]      count    [NUM_REQ];
    logic [RR_BW-1:0]       rr_ptr;

    logic [NUM_REQ-1:0]     not_empty;
    logic [NUM_REQ-1:0]     rdy;
    logic [NUM_REQ-1:0]     push;
    logic [NUM_REQ-1:0]     pop;
    logic                   found;
    logic [RR_BW-1:0]       win;
    logic [RR_BW-1:0]       rr_next;

    logic                   wen;
    logic [PHYS_IDX_BW-1:0] wr_idx;
    logic [DATA_BW-1:0]     wdata;
    logic [NUM_REQ-1:0]     grant;

    // Ready is a pure function of the stored count, so a full FIFO that pops
    // this cycle still reports not-ready; there is no vld->rdy path.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            not_empty[i] = (count[i] != '0);
            rdy[i]       = (count[i] != CNT_FULL);
            push[i]      = bus.i_req_vld[i] & rdy[i];
        end
    end

    // Round-robin search starting at rr_ptr. Only stored entries are
    // candidates, so a result pushed this cycle waits at least one cycle.
    always_comb begin
        int cand;
        cand  = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && not_empty[cand]) begin
                found = 1'b1;
                win   = RR_BW'(cand);
            end
        end
        pop = '0;
        if (found) begin
            pop[win] = 1'b1;
        end
        rr_next = (win == RR_LAST) ? '0 : win + RR_BW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                count[i]  <= '0;
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            rr_ptr <= '0;
            wen    <= 1'b0;
            wr_idx <= '0;
            wdata  <= '0;
            grant  <= '0;
        end else if (bus.i_flush) begin
            // Flush beats push and pop; write data/tag simply hold
            for (int i = 0; i < NUM_REQ; i++) begin
                count[i]  <= '0;
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            rr_ptr <= '0;
            wen    <= 1'b0;
            grant  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (push[i]) begin
                    idx_mem[i][wr_ptr[i]]  <= bus.i_req_idx[i*PHYS_IDX_BW +: PHYS_IDX_BW];
                    data_mem[i][wr_ptr[i]] <= bus.i_req_data[i*DATA_BW +: DATA_BW];
                    wr_ptr[i]              <= wr_ptr[i] + PTR_ONE;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CNT_ONE;
                    2'b01:   count[i] <= count[i] - CNT_ONE;
                    default: count[i] <= count[i];
                endcase
            end
            wen   <= found;
            grant <= pop;
            if (found) begin
                wr_idx <= idx_mem[win][rd_ptr[win]];
                wdata  <= data_mem[win][rd_ptr[win]];
                rr_ptr <= rr_next;
            end
        end
    end

    assign bus.o_req_rdy = rdy;
    assign bus.o_busy    = |not_empty;
    assign bus.o_wen     = wen;
    assign bus.o_wr_idx  = wr_idx;
    assign bus.o_wdata   = wdata;
    assign bus.o_grant   = grant;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_wb_arbiter
// Purpose  : Self-checking bench for rv32i_wb_arbiter: directed vector table,
//            hand-written multi-cycle sequences, and random traffic compared
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_wb_arbiter;

    localparam int NUM_REQ     = 3;
    localparam int PHYS_IDX_BW = 6;
    localparam int DATA_BW     = 32;
    localparam int BUF_DEPTH   = 2;
    localparam int NV          = 18;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    rv32i_wb_arbiter_if #(
        .NUM_REQ(NUM_REQ), .PHYS_IDX_BW(PHYS_IDX_BW), .DATA_BW(DATA_BW)
    ) bus ();

    rv32i_wb_arbiter #(
        .NUM_REQ(NUM_REQ), .PHYS_IDX_BW(PHYS_IDX_BW),
        .DATA_BW(DATA_BW), .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: one queue per requester plus the expected output regs
    logic [PHYS_IDX_BW-1:0] mq_idx [NUM_REQ][$];
    logic [DATA_BW-1:0]     mq_dat [NUM_REQ][$];
    int                     m_rr;
    logic                   e_wen;
    logic [NUM_REQ-1:0]     e_grant;
    logic [PHYS_IDX_BW-1:0] e_idx;
    logic [DATA_BW-1:0]     e_data;

    typedef struct {
        logic        rstn;
        logic        flush;
        logic [2:0]  vld;
        logic [5:0]  x0, x1, x2;
        logic [31:0] d0, d1, d2;
        logic        wen;
        logic [2:0]  grant;
        logic [5:0]  widx;
        logic [31:0] wdata;
        logic        busy;
        logic [2:0]  rdy;
    } vec_t;

    vec_t vt [NV];
    logic [DATA_BW-1:0] got1 [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic [2:0] v,
                         input logic [5:0] x0, input logic [5:0] x1, input logic [5:0] x2,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        rstn           = r;
        bus.i_flush    = f;
        bus.i_req_vld  = v;
        bus.i_req_idx  = {x2, x1, x0};
        bus.i_req_data = {d2, d1, d0};
    endtask

    // Applies one clock edge worth of the rules to the queue model
    task automatic model_step();
        int w;
        bit acc [NUM_REQ];
        if (!rstn) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                mq_idx[i].delete();
                mq_dat[i].delete();
            end
            m_rr = 0; e_wen = 0; e_grant = '0; e_idx = '0; e_data = '0;
        end else if (bus.i_flush) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                mq_idx[i].delete();
                mq_dat[i].delete();
            end
            m_rr = 0; e_wen = 0; e_grant = '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                acc[i] = bus.i_req_vld[i] && (mq_idx[i].size() < BUF_DEPTH);
            w = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                int j;
                j = (m_rr + k) % NUM_REQ;
                if (w < 0 && mq_idx[j].size() != 0) w = j;
            end
            if (w >= 0) begin
                e_wen   = 1;
                e_idx   = mq_idx[w].pop_front();
                e_data  = mq_dat[w].pop_front();
                e_grant = '0;
                e_grant[w] = 1'b1;
                m_rr    = (w + 1) % NUM_REQ;
            end else begin
                e_wen   = 0;
                e_grant = '0;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i]) begin
                    mq_idx[i].push_back(bus.i_req_idx[i*PHYS_IDX_BW +: PHYS_IDX_BW]);
                    mq_dat[i].push_back(bus.i_req_data[i*DATA_BW +: DATA_BW]);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [NUM_REQ-1:0] x_rdy;
        logic               x_busy;
        x_busy = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            x_rdy[i] = (mq_idx[i].size() < BUF_DEPTH);
            if (mq_idx[i].size() != 0) x_busy = 1;
        end
        chk({tag, "_wen"},   bus.o_wen,     e_wen);
        chk({tag, "_grant"}, bus.o_grant,   e_grant);
        chk({tag, "_idx"},   bus.o_wr_idx,  e_idx);
        chk({tag, "_data"},  bus.o_wdata,   e_data);
        chk({tag, "_busy"},  bus.o_busy,    x_busy);
        chk({tag, "_rdy"},   bus.o_req_rdy, x_rdy);
    endtask

    task automatic collect1();
        if (bus.o_wen && bus.o_grant == 3'b010) got1.push_back(bus.o_wdata);
    endtask

    initial begin
        // rstn flush vld  x0 x1 x2  d0 d1 d2 | wen grant widx wdata busy rdy
        vt[0]  = '{0,0,3'b000, 0, 0, 0, 0,0,0,                                   0,3'b000, 0,0,           0,3'b111};
        vt[1]  = '{1,0,3'b001, 5, 0, 0, 32'hDEADBEEF,0,0,                        0,3'b000, 0,0,           1,3'b111};
        vt[2]  = '{1,0,3'b000, 0, 0, 0, 0,0,0,                                   1,3'b001, 5,32'hDEADBEEF,0,3'b111};
        vt[3]  = '{1,0,3'b000, 0, 0, 0, 0,0,0,                                   0,3'b000, 5,32'hDEADBEEF,0,3'b111};
        vt[4]  = '{0,0,3'b000, 0, 0, 0, 0,0,0,                                   0,3'b000, 0,0,           0,3'b111};
        vt[5]  = '{1,0,3'b111, 1, 2, 3, 32'hA1A10001,32'hA2A20002,32'hA3A30003,  0,3'b000, 0,0,           1,3'b111};
        vt[6]  = '{1,0,3'b000, 0, 0, 0, 0,0,0,                                   1,3'b001, 1,32'hA1A10001,1,3'b111};
        vt[7]  = '{1,0,3'b000, 0, 0, 0, 0,0,0,                                   1,3'b010, 2,32'hA2A20002,1,3'b111};
        vt[8]  = '{1,0,3'b000, 0, 0, 0, 0,0,0,                                   1,3'b100, 3,32'hA3A30003,0,3'b111};
        vt[9]  = '{1,0,3'b000, 0, 0, 0, 0,0,0,                                   0,3'b000, 3,32'hA3A30003,0,3'b111};
        vt[10] = '{1,0,3'b101,10, 0,12, 32'h100,0,32'h300,                        0,3'b000, 3,32'hA3A30003,1,3'b111};
        vt[11] = '{1,0,3'b101,10, 0,12, 32'h100,0,32'h300,                        1,3'b001,10,32'h100,     1,3'b011};
        vt[12] = '{1,0,3'b101,10, 0,12, 32'h100,0,32'h300,                        1,3'b100,12,32'h300,     1,3'b110};
        vt[13] = '{1,0,3'b101,10, 0,12, 32'h100,0,32'h300,                        1,3'b001,10,32'h100,     1,3'b011};
        vt[14] = '{1,0,3'b101,10, 0,12, 32'h100,0,32'h300,                        1,3'b100,12,32'h300,     1,3'b110};
        vt[15] = '{1,0,3'b000, 0, 0, 0, 0,0,0,                                   1,3'b001,10,32'h100,     1,3'b111};
        vt[16] = '{1,0,3'b000, 0, 0, 0, 0,0,0,                                   1,3'b100,12,32'h300,     1,3'b111};
        vt[17] = '{1,0,3'b000, 0, 0, 0, 0,0,0,                                   1,3'b001,10,32'h100,     0,3'b111};

        drive(0, 0, 3'b000, 0, 0, 0, 0, 0, 0);

        // Directed vector table
        for (int n = 0; n < NV; n++) begin
            drive(vt[n].rstn, vt[n].flush, vt[n].vld, vt[n].x0, vt[n].x1, vt[n].x2,
                  vt[n].d0, vt[n].d1, vt[n].d2);
            tick();
            chk($sformatf("v%0d_wen", n),   bus.o_wen,     vt[n].wen);
            chk($sformatf("v%0d_grant", n), bus.o_grant,   vt[n].grant);
            chk($sformatf("v%0d_idx", n),   bus.o_wr_idx,  vt[n].widx);
            chk($sformatf("v%0d_data", n),  bus.o_wdata,   vt[n].wdata);
            chk($sformatf("v%0d_busy", n),  bus.o_busy,    vt[n].busy);
            chk($sformatf("v%0d_rdy", n),   bus.o_req_rdy, vt[n].rdy);
        end

        // Unit1 back-pressure: third value must wait for a pop, order kept
        drive(0, 0, 3'b000, 0, 0, 0, 0, 0, 0); tick(); check_model("t4_rst");
        drive(1, 0, 3'b111, 20, 21, 22, 32'h20, 32'h1111000A, 32'h22); tick(); check_model("t4_a"); collect1();
        drive(1, 0, 3'b111, 20, 21, 22, 32'h20, 32'h1111000B, 32'h22); tick(); check_model("t4_b"); collect1();
        chk("t4_rdy1_full", bus.o_req_rdy[1], 1'b0);
        drive(1, 0, 3'b111, 20, 21, 22, 32'h20, 32'h1111000C, 32'h22); tick(); check_model("t4_c"); collect1();
        drive(1, 0, 3'b111, 20, 21, 22, 32'h20, 32'h1111000C, 32'h22); tick(); check_model("t4_d"); collect1();
        drive(1, 0, 3'b101, 20, 21, 22, 32'h20, 32'h1111000D, 32'h22); tick(); check_model("t4_e"); collect1();
        drive(1, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 6; n++) begin
            tick(); check_model("t4_drain"); collect1();
        end
        chk("t4_u1_count", got1.size(), 3);
        if (got1.size() == 3) begin
            chk("t4_u1_first",  got1[0], 32'h1111000A);
            chk("t4_u1_second", got1[1], 32'h1111000B);
            chk("t4_u1_third",  got1[2], 32'h1111000C);
        end

        // Flush with four buffered entries and a unit0 value on the inputs
        drive(0, 0, 3'b000, 0, 0, 0, 0, 0, 0); tick(); check_model("t5_rst");
        drive(1, 0, 3'b011, 30, 31, 0, 32'h30, 32'h31, 0); tick(); check_model("t5_p1");
        drive(1, 0, 3'b011, 30, 31, 0, 32'h30, 32'h31, 0); tick(); check_model("t5_p2");
        drive(1, 0, 3'b101, 32, 0, 34, 32'h32, 0, 32'h34); tick(); check_model("t5_p3");
        chk("t5_busy_before", bus.o_busy, 1'b1);
        drive(1, 1, 3'b001, 6'h3F, 0, 0, 32'hBAD0BAD0, 0, 0); tick(); check_model("t5_flush");
        chk("t5_wen_after", bus.o_wen, 1'b0);
        chk("t5_busy_after", bus.o_busy, 1'b0);
        chk("t5_rdy_after", bus.o_req_rdy, 3'b111);
        drive(1, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 4; n++) begin
            tick(); check_model("t5_idle");
            chk("t5_no_write", bus.o_wen, 1'b0);
        end

        // Reset in the middle of traffic
        drive(1, 0, 3'b111, 40, 41, 42, 32'h40, 32'h41, 32'h42); tick(); check_model("t6_push");
        drive(1, 0, 3'b000, 0, 0, 0, 0, 0, 0); tick(); check_model("t6_run");
        chk("t6_wen_live", bus.o_wen, 1'b1);
        drive(0, 0, 3'b111, 43, 44, 45, 32'h43, 32'h44, 32'h45); tick(); check_model("t6_rst");
        chk("t6_rst_wen", bus.o_wen, 1'b0);
        chk("t6_rst_grant", bus.o_grant, 3'b000);
        chk("t6_rst_idx", bus.o_wr_idx, 6'd0);
        chk("t6_rst_data", bus.o_wdata, 32'd0);
        chk("t6_rst_busy", bus.o_busy, 1'b0);
        drive(1, 0, 3'b111, 50, 51, 52, 32'h50, 32'h51, 32'h52); tick(); check_model("t6_push2");
        drive(1, 0, 3'b000, 0, 0, 0, 0, 0, 0); tick(); check_model("t6_first");
        chk("t6_first_grant", bus.o_grant, 3'b001);

        // Random traffic against the queue model
        drive(0, 0, 3'b000, 0, 0, 0, 0, 0, 0); tick(); check_model("rnd_rst");
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 299) != 0), ($urandom_range(0, 49) == 0),
                  3'($urandom), 6'($urandom), 6'($urandom), 6'($urandom),
                  $urandom, $urandom, $urandom);
            tick();
            check_model("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
